// File: rtl/sub_serial.sv
// Bit-serial N-bit subtractor (a - b), LSB first, one bit per clock.
// Optional macro SUB_SERIAL_ABS_EN loads |a - b| into diff instead of the raw result.
module sub_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         busy,
  output logic         done
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           c_q, c_d, borrow_q, borrow_d;
  logic           accept, last, d_bit, c_next;
  logic [N-1:0]   raw;

  // start is only honoured when no operation is in flight
  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign last   = (cnt_q == CW'(N - 1));
  assign d_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & c_q);
  assign raw    = {d_bit, res_q[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      res_d = '0;
      cnt_d = '0;
      c_d   = 1'b0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = raw;
      cnt_d = cnt_q + CW'(1);
      c_d   = c_next;
      if (last) begin
`ifdef SUB_SERIAL_ABS_EN
        diff_d = c_next ? (~raw + N'(1)) : raw;
`else
        diff_d = raw;
`endif
        borrow_d = c_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
endmodule
